instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter BEGINNING_TEXT, default 64'h0000_0000_0040_0000, first byte address of user .text.
REQ-002 Parameter END_TEXT, default 64'h0000_0000_0040_0FFF, last byte address of user .text.
REQ-003 Parameter RESET_PC, default BEGINNING_TEXT, PC loaded on reset.
REQ-004 iCLK  in  1  single clock; all state updates on rising edge.
REQ-005 iRST  in  1  reset, synchronous, active-high.
REQ-006 oMemAddress  out  64  byte address to code memory; word-aligned.
REQ-007 oMemReadEnable  out  1  read request strobe to code memory.
REQ-008 iMemReadData  in  32  instruction word; valid exactly 1 cycle after the request cycle.
REQ-009 iBranchTaken  in  1  one-cycle redirect pulse from execute.
REQ-010 iBranchTarget  in  64  redirect byte address, sampled when iBranchTaken=1.
REQ-011 oInstrValid  out  1  oInstr/oPC hold a fetched instruction.
REQ-012 iInstrReady  in  1  decoder accepts; transfer when oInstrValid && iInstrReady.
REQ-013 oInstr  out  32  instruction word at buffer head.
REQ-014 oPC  out  64  byte address of oInstr.
REQ-015 oFault  out  1  fetch fault (misaligned or outside .text) held.
REQ-016 oFaultAddr  out  64  PC that caused the fault.

Function
REQ-017 States: RUN, FAULT; RUN after reset.
REQ-018 2-entry FIFO of {pc, instr}; plus in-flight flag (at most 1 outstanding request) and squash flag.
REQ-019 Credit rule: in RUN, request issued in a cycle iff count + inflight - pop < 2, and no redirect that cycle.
REQ-020 Request: oMemReadEnable=1, oMemAddress=PC; PC <= PC+4 at end of cycle.
REQ-021 Response: cycle after a request, iMemReadData pushed with its request PC unless squashed.
REQ-022 Latency: request at cycle N -> oInstrValid=1 at cycle N+2; no combinational bypass.
REQ-023 Throughput: with iInstrReady held 1, one request and one delivery per cycle in steady state.
REQ-024 Empty FIFO: oInstrValid=0, oInstr=0, oPC=0.
REQ-025 Pop on oInstrValid && iInstrReady; simultaneous push and pop keeps count unchanged, order preserved.
REQ-026 Fetch check: before issuing, if PC[1:0]!=0 or PC<BEGINNING_TEXT or PC>END_TEXT-3, no request; state->FAULT, oFault=1, oFaultAddr=PC.
REQ-027 FAULT: no requests; FIFO keeps draining to decoder; oFault and oFaultAddr held.
REQ-028 Redirect (iBranchTaken=1): FIFO flushed, outstanding response squashed, PC <= iBranchTarget, oFault cleared, state->RUN, no request that cycle; first target request next cycle.
REQ-029 Redirect has priority over pop, push and fault detection in the same cycle; popped entry still counts as delivered.
REQ-030 PC+4 wraps modulo 2^64; wrapped PC is then caught by REQ-026.

Reset
REQ-031 iRST=1 at an edge: PC=RESET_PC, FIFO empty, inflight=0, squash=0, state=RUN, oFault=0, oFaultAddr=0.
REQ-032 During iRST=1: oMemReadEnable=0, oInstrValid=0; iRST overrides iBranchTaken.
REQ-033 Mid-operation reset discards buffered and in-flight instructions; first request in first cycle with iRST=0.

Verification
REQ-034 Reset, ready=1, memory returns addr-tagged words -> requests 0x400000, 0x400004, ... every cycle; oPC=0x400000 valid 2 cycles after first request.
REQ-035 ready=0 for 5 cycles -> exactly 2 buffered, requests stop; ready=1 -> in-order delivery, no loss or duplicate.
REQ-036 iBranchTaken with target 0x400100 while FIFO full and request outstanding -> next oInstrValid shows oPC=0x400100; stale words never appear.
REQ-037 Target 0x400102 -> no request, oFault=1, oFaultAddr=0x400102; then target 0x400000 -> oFault=0, fetch resumes.
REQ-038 Sequential fetch up to END_TEXT-3=0x400FFC -> next PC 0x401000 faults, oFaultAddr=0x401000; buffered instructions still delivered.
REQ-039 iRST asserted with 2 buffered and 1 in flight -> next cycle oInstrValid=0, oFault=0, first request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to code memory one cycle ahead of a
// 2-entry {pc, instr} buffer, with .text bounds checking and branch redirect.
module instr_fetch_unit #(
   parameter logic [63:0] BEGINNING_TEXT = 64'h0000_0000_0040_0000,
   parameter logic [63:0] END_TEXT       = 64'h0000_0000_0040_0FFF,
   parameter logic [63:0] RESET_PC       = BEGINNING_TEXT
) (
   input  logic        iCLK,
   input  logic        iRST,
   output logic [63:0] oMemAddress,
   output logic        oMemReadEnable,
   input  logic [31:0] iMemReadData,
   input  logic        iBranchTaken,
   input  logic [63:0] iBranchTarget,
   output logic        oInstrValid,
   input  logic        iInstrReady,
   output logic [31:0] oInstr,
   output logic [63:0] oPC,
   output logic        oFault,
   output logic [63:0] oFaultAddr
);

   localparam logic [0:0]  ST_RUN     = 1'b0;
   localparam logic [0:0]  ST_FAULT   = 1'b1;
   localparam logic [63:0] LAST_FETCH = END_TEXT - 64'd3;

   logic [0:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_pc_q, req_pc_d;
   logic        inflight_q, inflight_d;
   logic        squash_q, squash_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        fault_q, fault_d;
   logic [63:0] fault_addr_q, fault_addr_d;

   logic [63:0] fifo_pc_q    [2];
   logic [31:0] fifo_instr_q [2];
   logic        fifo_wr_en   [2];

   logic        fifo_valid;
   logic        pop;
   logic        push;
   logic        redirect;
   logic        pc_bad;
   logic        run_ok;
   logic        fault_hit;
   logic        issue;
   logic [1:0]  occupancy;

   // Buffer head is only visible when non-empty and not in reset.
   assign fifo_valid  = (count_q != 2'd0) && !iRST;
   assign oInstrValid = fifo_valid;
   assign oInstr      = fifo_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
   assign oPC         = fifo_valid ? fifo_pc_q[rd_ptr_q] : 64'd0;
   assign pop         = fifo_valid && iInstrReady;

   assign redirect  = iBranchTaken && !iRST;
   assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q < BEGINNING_TEXT) || (pc_q > LAST_FETCH);
   assign run_ok    = (state_q == ST_RUN) && !redirect && !iRST;
   assign fault_hit = run_ok && pc_bad;

   // Slots that will be occupied once this cycle's response lands and head leaves.
   assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
   assign issue     = run_ok && !pc_bad && (occupancy < 2'd2);

   assign oMemReadEnable = issue;
   assign oMemAddress    = {pc_q[63:2], 2'b00};
   assign oFault         = fault_q;
   assign oFaultAddr     = fault_addr_q;

   // A response is dropped if it belongs to a request made before a redirect.
   assign push = inflight_q && !squash_q && !redirect;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      inflight_d   = 1'b0;
      squash_d     = 1'b0;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;

      if (redirect) begin
         state_d  = ST_RUN;
         pc_d     = iBranchTarget;
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         fault_d  = 1'b0;
         squash_d = inflight_q;
      end else begin
         if (push) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};

         if (fault_hit) begin
            state_d      = ST_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = pc_q;
         end

         if (issue) begin
            pc_d       = pc_q + 64'd4;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         req_pc_q     <= 64'd0;
         inflight_q   <= 1'b0;
         squash_q     <= 1'b0;
         count_q      <= 2'd0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         fault_q      <= 1'b0;
         fault_addr_q <= 64'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         inflight_q   <= inflight_d;
         squash_q     <= squash_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   // Payload storage needs no reset: count_q alone decides what is visible.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         assign fifo_wr_en[gi] = push && (wr_ptr_q == gi[0]) && !iRST;

         always_ff @(posedge iCLK) begin
            if (fifo_wr_en[gi]) begin
               fifo_pc_q[gi]    <= req_pc_q;
               fifo_instr_q[gi] <= iMemReadData;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: expected request and delivery
// streams are regenerated from the .text rules on every reset or redirect.
module tb_instr_fetch_unit;

   localparam logic [63:0] B   = 64'h0000_0000_0040_0000;
   localparam logic [63:0] E   = 64'h0000_0000_0040_0FFF;
   localparam logic [63:0] RPC = B;

   logic        clk = 1'b0;
   logic        iRST;
   logic [63:0] oMemAddress;
   logic        oMemReadEnable;
   logic [31:0] iMemReadData;
   logic        iBranchTaken;
   logic [63:0] iBranchTarget;
   logic        oInstrValid;
   logic        iInstrReady;
   logic [31:0] oInstr;
   logic [63:0] oPC;
   logic        oFault;
   logic [63:0] oFaultAddr;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .BEGINNING_TEXT(B),
      .END_TEXT(E),
      .RESET_PC(RPC)
   ) dut (
      .iCLK(clk),
      .iRST(iRST),
      .oMemAddress(oMemAddress),
      .oMemReadEnable(oMemReadEnable),
      .iMemReadData(iMemReadData),
      .iBranchTaken(iBranchTaken),
      .iBranchTarget(iBranchTarget),
      .oInstrValid(oInstrValid),
      .iInstrReady(iInstrReady),
      .oInstr(oInstr),
      .oPC(oPC),
      .oFault(oFault),
      .oFaultAddr(oFaultAddr)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] del_q [$];
   logic [63:0] req_q [$];
   logic [63:0] exp_fault = 64'd0;
   bit          fault_seen = 1'b0;
   bit          post_flush = 1'b0;
   int          occ = 0;
   bit          last_en = 1'b0;
   logic [63:0] last_addr = 64'd0;

   function automatic logic [31:0] tag(input logic [63:0] a);
      return a[31:0] ^ 32'hC0DE_0000;
   endfunction

   function automatic bit legal(input logic [63:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= B) && (pc <= E - 64'd3);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // The fetch stream from a start PC is every legal word in order; the first illegal one faults.
   function automatic void refill(input logic [63:0] start);
      logic [63:0] pc;
      int n;
      del_q.delete();
      req_q.delete();
      pc = start;
      n  = 0;
      while (legal(pc) && n < 2048) begin
         del_q.push_back(pc);
         req_q.push_back(pc);
         pc = pc + 64'd4;
         n++;
      end
      exp_fault  = pc;
      occ        = 0;
      fault_seen = 1'b0;
      post_flush = 1'b1;
   endfunction

   // Code memory: answers the previous cycle's request one cycle later.
   always @(posedge clk) begin
      #1;
      iMemReadData = last_en ? tag(last_addr) : $urandom;
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (iRST) begin
         chk("rst_valid", oInstrValid, 0);
         chk("rst_req", oMemReadEnable, 0);
         refill(RPC);
         last_en = 1'b0;
      end else begin
         if (post_flush) begin
            chk("flush_valid", oInstrValid, 0);
            chk("flush_fault", oFault, 0);
            post_flush = 1'b0;
         end
         if (!oInstrValid) begin
            chk("idle_instr", oInstr, 0);
            chk("idle_pc", oPC, 0);
         end
         if (oInstrValid && iInstrReady) begin
            if (del_q.size() == 0) begin
               chk("deliver_extra", oPC, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               logic [63:0] e;
               e = del_q.pop_front();
               chk("deliver_pc", oPC, e);
               chk("deliver_instr", oInstr, tag(e));
               occ--;
            end
         end
         if (oFault && !fault_seen) begin
            chk("fault_addr", oFaultAddr, exp_fault);
            chk("fault_pending_reqs", req_q.size(), 0);
            fault_seen = 1'b1;
         end
         if (iBranchTaken) begin
            chk("redirect_noreq", oMemReadEnable, 0);
            refill(iBranchTarget);
         end else if (oMemReadEnable) begin
            chk("req_in_fault", oFault, 0);
            if (req_q.size() == 0) begin
               chk("req_extra", oMemAddress, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("req_addr", oMemAddress, req_q.pop_front());
            end
            occ++;
            chk("credit", occ <= 2, 1);
         end
         last_en   = oMemReadEnable;
         last_addr = oMemAddress;
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fault(input int lim, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!oFault && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(name, oFault, 1);
   endtask

   task automatic wait_valid(input int lim, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!oInstrValid && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(name, oInstrValid, 1);
   endtask

   function automatic logic [63:0] pick_target();
      logic [63:0] t;
      case ($urandom_range(0, 5))
         0, 1:    t = B + 64'(4 * $urandom_range(0, 1023));
         2:       t = (E - 64'd3) - 64'(4 * $urandom_range(0, 6));
         3:       t = B + 64'(4 * $urandom_range(0, 1023)) + 64'($urandom_range(1, 3));
         4:       t = B - 64'd4;
         default: t = E + 64'd1;
      endcase
      return t;
   endfunction

   initial begin
      int n;
      iRST          = 1'b1;
      iBranchTaken  = 1'b0;
      iBranchTarget = 64'd0;
      iInstrReady   = 1'b1;
      iMemReadData  = 32'd0;

      repeat (3) @(posedge clk);
      #1 iRST = 1'b0;

      // First request right after reset, delivery two cycles later.
      @(negedge clk);
      chk("first_req_en", oMemReadEnable, 1);
      chk("first_req_addr", oMemAddress, B);
      @(negedge clk);
      chk("lat_n1_valid", oInstrValid, 0);
      @(negedge clk);
      chk("lat_n2_valid", oInstrValid, 1);
      chk("lat_n2_pc", oPC, B);
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (oMemReadEnable && oInstrValid) n++;
      end
      chk("throughput", n, 8);

      // Back-pressure: buffer fills to two and requests stop.
      drive_edge();
      iInstrReady = 1'b0;
      repeat (5) @(negedge clk);
      chk("stall_noreq", oMemReadEnable, 0);
      chk("stall_valid", oInstrValid, 1);
      drive_edge();
      iInstrReady = 1'b1;
      repeat (6) drive_edge();

      // Redirect with an outstanding request.
      iInstrReady = 1'b0;
      drive_edge();
      iBranchTaken  = 1'b1;
      iBranchTarget = 64'h40_0100;
      drive_edge();
      iBranchTaken = 1'b0;
      iInstrReady  = 1'b1;
      wait_valid(10, "redir_valid");
      chk("redir_pc", oPC, 64'h40_0100);

      // Misaligned target faults, then a good target recovers.
      drive_edge();
      iBranchTaken  = 1'b1;
      iBranchTarget = 64'h40_0102;
      drive_edge();
      iBranchTaken = 1'b0;
      wait_fault(10, "mis_fault");
      chk("mis_addr", oFaultAddr, 64'h40_0102);
      chk("mis_noreq", oMemReadEnable, 0);
      drive_edge();
      iBranchTaken  = 1'b1;
      iBranchTarget = B;
      drive_edge();
      iBranchTaken = 1'b0;
      @(negedge clk);
      chk("recover_fault", oFault, 0);
      chk("recover_req", oMemReadEnable, 1);
      chk("recover_addr", oMemAddress, B);

      // Run off the end of .text.
      drive_edge();
      iBranchTaken  = 1'b1;
      iBranchTarget = 64'h40_0FF0;
      drive_edge();
      iBranchTaken = 1'b0;
      wait_fault(20, "end_fault");
      chk("end_addr", oFaultAddr, 64'h40_1000);
      repeat (4) @(negedge clk);
      chk("end_drained", del_q.size(), 0);

      // Mid-operation reset with a full buffer.
      drive_edge();
      iBranchTaken  = 1'b1;
      iBranchTarget = B + 64'h40;
      drive_edge();
      iBranchTaken = 1'b0;
      iInstrReady  = 1'b0;
      repeat (4) drive_edge();
      iRST = 1'b1;
      drive_edge();
      iRST        = 1'b0;
      iInstrReady = 1'b1;
      @(negedge clk);
      chk("mrst_valid", oInstrValid, 0);
      chk("mrst_fault", oFault, 0);
      chk("mrst_req", oMemReadEnable, 1);
      chk("mrst_addr", oMemAddress, RPC);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         drive_edge();
         iRST          = ($urandom_range(0, 199) == 0);
         iBranchTaken  = !iRST && ($urandom_range(0, 29) == 0);
         iBranchTarget = pick_target();
         iInstrReady   = ($urandom_range(0, 3) != 0);
      end
      drive_edge();
      iRST         = 1'b0;
      iBranchTaken = 1'b0;
      iInstrReady  = 1'b1;
      repeat (10) drive_edge();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
